password_seq_lock: RTL



---
 rtl/password_seq_lock.sv | 138 +++++++++++++
 1 files changed

// File: rtl/password_seq_lock.sv
// password_seq_lock: switch-sequence combination lock with rising-edge entry, fail counter and timed lockout
module password_seq_lock #(
  parameter int                   SW_W     = 10,
  parameter int                   LEN      = 4,
  parameter int                   IDX_W    = 4,
  parameter logic [LEN*IDX_W-1:0] CODE     = {4'd1, 4'd7, 4'd2, 4'd0},
  parameter int                   MAX_FAIL = 3,
  parameter int                   LOCK_CYC = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw,
  output logic [LEN-1:0]  progress,
  output logic            unlocked,
  output logic            error,
  output logic            locked,
  output logic [3:0]      fail_cnt,
  output logic [6:0]      hex0,
  output logic [6:0]      hex1,
  output logic [6:0]      hex2,
  output logic [6:0]      hex3,
  output logic [6:0]      hex4
);
  localparam int IW = $clog2(LEN) + 1;
  localparam int TW = $clog2(LOCK_CYC) + 1;
  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_DONE, S_ERROR, S_LOCK} state_t;
  state_t          r_state, w_next;
  logic [IW-1:0]   r_idx, w_idx_n;
  logic [3:0]      r_fail, w_fail_n;
  logic [TW-1:0]   r_tmr, w_tmr_n;
  logic [SW_W-1:0] r_sync, r_sw_s, r_sw_q, w_rise, w_exp;
  logic [1:0]      r_rdy;
  logic [LEN-1:0]  w_prog;
  logic [6:0]      w_hex [5];
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'h40; 4'h1: seg = 7'h79; 4'h2: seg = 7'h24; 4'h3: seg = 7'h30;
      4'h4: seg = 7'h19; 4'h5: seg = 7'h12; 4'h6: seg = 7'h02; 4'h7: seg = 7'h78;
      4'h8: seg = 7'h00; 4'h9: seg = 7'h10; 4'hA: seg = 7'h08; 4'hB: seg = 7'h03;
      4'hC: seg = 7'h46; 4'hD: seg = 7'h21; 4'hE: seg = 7'h06; default: seg = 7'h0E;
    endcase
  endfunction
  assign w_rise   = r_sw_s & ~r_sw_q;
  assign fail_cnt = r_fail;
  always_comb begin
    w_exp = '0;
    for (int k = 0; k < LEN; k++)
      if (r_idx == IW'(k)) w_exp = SW_W'(1) << CODE[(LEN-1-k)*IDX_W +: IDX_W];
  end
  // r_rdy keeps IDLE from arming until the synchroniser holds real switch levels,
  // so a switch already high across reset release is never seen as a rise
  always_comb begin
    w_next   = r_state;
    w_idx_n  = r_idx;
    w_fail_n = r_fail;
    w_tmr_n  = r_tmr;
    case (r_state)
      S_IDLE: if (r_sw_s == '0 && r_rdy[1]) begin
        w_next  = S_ENTRY;
        w_idx_n = '0;
      end
      S_ENTRY: if (w_rise != '0) begin
        if (w_rise == w_exp) begin
          w_idx_n = r_idx + IW'(1);
          if (r_idx == IW'(LEN-1)) begin
            w_next   = S_DONE;
            w_fail_n = '0;
          end
        end else begin
          w_fail_n = r_fail + 4'd1;
          w_next   = (w_fail_n == 4'(MAX_FAIL)) ? S_LOCK : S_ERROR;
          w_tmr_n  = (w_next == S_LOCK) ? TW'(LOCK_CYC-1) : r_tmr;
        end
      end
      S_DONE, S_ERROR: w_next = (r_sw_s == '0) ? S_IDLE : r_state;
      S_LOCK: if (r_tmr != '0) w_tmr_n = r_tmr - TW'(1);
        else if (r_sw_s == '0) begin
          w_next   = S_IDLE;
          w_fail_n = '0;
          w_tmr_n  = '0;
        end
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    for (int k = 0; k < LEN; k++)
      w_prog[k] = (w_next == S_DONE) || (w_next == S_ENTRY && k < int'(w_idx_n));
    for (int k = 0; k < 5; k++)
      w_hex[k] = (w_next == S_ENTRY && k < int'(w_idx_n)) ? 7'h3F : 7'h7F;
    if (w_next == S_DONE) begin
      w_hex[3] = 7'h21; w_hex[2] = 7'h23; w_hex[1] = 7'h2B; w_hex[0] = 7'h06;
    end else if (w_next == S_ERROR) begin
      w_hex[4] = 7'h06; w_hex[3] = 7'h2F; w_hex[2] = 7'h2F; w_hex[1] = 7'h23; w_hex[0] = 7'h2F;
    end else if (w_next == S_LOCK) begin
      w_hex[4] = seg(w_fail_n);
      w_hex[3] = 7'h47; w_hex[2] = 7'h40; w_hex[1] = 7'h46; w_hex[0] = 7'h21;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_fail   <= '0;
      r_tmr    <= '0;
      r_sync   <= '0;
      r_sw_s   <= '0;
      r_sw_q   <= '0;
      r_rdy    <= '0;
      progress <= '0;
      unlocked <= 1'b0;
      error    <= 1'b0;
      locked   <= 1'b0;
      hex0     <= 7'h7F;
      hex1     <= 7'h7F;
      hex2     <= 7'h7F;
      hex3     <= 7'h7F;
      hex4     <= 7'h7F;
    end else begin
      r_state  <= w_next;
      r_idx    <= w_idx_n;
      r_fail   <= w_fail_n;
      r_tmr    <= w_tmr_n;
      r_sync   <= sw;
      r_sw_s   <= r_sync;
      r_sw_q   <= r_sw_s;
      r_rdy    <= {r_rdy[0], 1'b1};
      progress <= w_prog;
      unlocked <= (w_next == S_DONE);
      error    <= (w_next == S_ERROR);
      locked   <= (w_next == S_LOCK);
      hex0     <= w_hex[0];
      hex1     <= w_hex[1];
      hex2     <= w_hex[2];
      hex3     <= w_hex[3];
      hex4     <= w_hex[4];
    end
  end
endmodule
